msip_injector: RTL

- Sits directly downstream of the coverage stall monitor in the fuzzing testbench.
- Converts the monitor's raw stall level into a disciplined machine-software-interrupt (MSIP) drive for the core pipeline.
- Bounds how long MSIP is held, enforces a cooldown between injections, and tracks injections per round.
- Requests round termination (give_up) when repeated injections produce no coverage progress, so the fuzz manager can end the round early.

---
 rtl/msip_injector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/msip_injector.sv
// msip_injector
// Turns the coverage monitor's raw stall level into a controlled
// machine-software-interrupt drive for the core pipeline. Each MSIP pulse is
// held for a bounded time and followed by a cooldown. Injections that bring no
// coverage progress count as strikes. When the strike budget is used up, a
// one-cycle give_up pulse asks the fuzz manager to end the round.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   stall_i      stall/watchdog level from the coverage monitor
//   cov          live coverage sum from the DUT
//   round_done   current fuzz round has finished (tohost bit 0)
//   trap_ack     core has taken the software-interrupt trap
//   msip         registered drive for io_interrupts_msip
//   give_up      registered one-cycle round-termination request
//   inject_count injections issued in the current round (saturating)
//   state        FSM state: 0 IDLE, 1 ASSERT, 2 COOLDOWN, 3 GAVE_UP
module msip_injector #(
  parameter int COV_W      = 30,
  parameter int HOLD_MAX   = 64,
  parameter int COOLDOWN   = 256,
  parameter int MAX_INJECT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_i,
  input  logic [COV_W-1:0] cov,
  input  logic             round_done,
  input  logic             trap_ack,
  output logic             msip,
  output logic             give_up,
  output logic [CNT_W-1:0] inject_count,
  output logic [1:0]       state
);

  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int COOL_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  // Strikes must be able to hold the value MAX_INJECT itself.
  localparam int STRK_W = $clog2(MAX_INJECT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_MAX - 1);
  localparam logic [COOL_W-1:0] COOL_LAST  = COOL_W'(COOLDOWN - 1);
  localparam logic [STRK_W-1:0] STRK_LIMIT = STRK_W'(MAX_INJECT);
  localparam logic [CNT_W-1:0]  CNT_SAT    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_GAVE_UP  = 2'd3
  } state_e;

  state_e             state_r;
  state_e             state_s;
  logic               msip_r;
  logic               msip_s;
  logic               give_up_r;
  logic               give_up_s;
  logic [CNT_W-1:0]   inject_count_r;
  logic [CNT_W-1:0]   inject_count_s;
  logic [STRK_W-1:0]  strikes_r;
  logic [STRK_W-1:0]  strikes_s;
  logic [STRK_W-1:0]  strikes_eff_s;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [HOLD_W-1:0]  hold_cnt_s;
  logic [COOL_W-1:0]  cool_cnt_r;
  logic [COOL_W-1:0]  cool_cnt_s;
  logic [COV_W-1:0]   pre_cov_r;
  logic               progress_s;

  // Progress detection: any change of the coverage sum since last cycle
  // wipes the strike count before this cycle's decision uses it.
  always_comb begin
    progress_s    = (cov != pre_cov_r);
    strikes_eff_s = strikes_r;
    if (progress_s) begin
      strikes_eff_s = {STRK_W{1'b0}};
    end else begin
      strikes_eff_s = strikes_r;
    end
  end

  // Next-state and next-output logic; round_done overrides every state.
  always_comb begin
    state_s        = state_r;
    inject_count_s = inject_count_r;
    strikes_s      = strikes_eff_s;
    hold_cnt_s     = hold_cnt_r;
    cool_cnt_s     = cool_cnt_r;
    give_up_s      = 1'b0;

    if (round_done) begin
      state_s        = ST_IDLE;
      inject_count_s = {CNT_W{1'b0}};
      strikes_s      = {STRK_W{1'b0}};
      hold_cnt_s     = {HOLD_W{1'b0}};
      cool_cnt_s     = {COOL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (stall_i) begin
            if (strikes_eff_s < STRK_LIMIT) begin
              state_s    = ST_ASSERT;
              strikes_s  = strikes_eff_s + STRK_W'(1);
              hold_cnt_s = {HOLD_W{1'b0}};
              if (inject_count_r != CNT_SAT) begin
                inject_count_s = inject_count_r + CNT_W'(1);
              end else begin
                inject_count_s = inject_count_r;
              end
            end else begin
              state_s   = ST_GAVE_UP;
              give_up_s = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ASSERT: begin
          // An ack or the hold limit ends the pulse, whichever comes first.
          if (trap_ack || (hold_cnt_r == HOLD_LAST)) begin
            state_s    = ST_COOLDOWN;
            cool_cnt_s = {COOL_W{1'b0}};
            hold_cnt_s = {HOLD_W{1'b0}};
          end else begin
            hold_cnt_s = hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_COOLDOWN: begin
          // stall_i and trap_ack are deliberately ignored while cooling down.
          if (cool_cnt_r == COOL_LAST) begin
            state_s    = ST_IDLE;
            cool_cnt_s = {COOL_W{1'b0}};
          end else begin
            cool_cnt_s = cool_cnt_r + COOL_W'(1);
          end
        end
        ST_GAVE_UP: begin
          // Sticky until round_done or reset; progress alone does not leave.
          state_s = ST_GAVE_UP;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

    msip_s = (state_s == ST_ASSERT);
  end

  // State, counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      msip_r         <= 1'b0;
      give_up_r      <= 1'b0;
      inject_count_r <= {CNT_W{1'b0}};
      strikes_r      <= {STRK_W{1'b0}};
      hold_cnt_r     <= {HOLD_W{1'b0}};
      cool_cnt_r     <= {COOL_W{1'b0}};
      pre_cov_r      <= {COV_W{1'b0}};
    end else begin
      state_r        <= state_s;
      msip_r         <= msip_s;
      give_up_r      <= give_up_s;
      inject_count_r <= inject_count_s;
      strikes_r      <= strikes_s;
      hold_cnt_r     <= hold_cnt_s;
      cool_cnt_r     <= cool_cnt_s;
      pre_cov_r      <= cov;
    end
  end

  assign msip         = msip_r;
  assign give_up      = give_up_r;
  assign inject_count = inject_count_r;
  assign state        = state_r;

endmodule
